// File: rtl/tap_if.sv
// TAP controller signal bundle: TMS steering input plus the registered
// state and the per-state decodes consumed by the scan output logic.
interface tap_if;
    logic       TMS;
    logic [3:0] tap_state;
    logic       tlr_reset;
    logic       run_idle;
    logic       dr_capture;
    logic       dr_shift;
    logic       dr_update;
    logic       ir_capture;
    logic       ir_shift;
    logic       ir_update;
    logic       ir_select;

    // Host side: drives TMS, observes the controller state and decodes.
    modport master (
        output TMS,
        input  tap_state, tlr_reset, run_idle,
        input  dr_capture, dr_shift, dr_update,
        input  ir_capture, ir_shift, ir_update, ir_select
    );

    // Controller side: samples TMS, publishes state and decodes.
    modport slave (
        input  TMS,
        output tap_state, tlr_reset, run_idle,
        output dr_capture, dr_shift, dr_update,
        output ir_capture, ir_shift, ir_update, ir_select
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state Moore FSM clocked by TCK and steered
// by TMS. The state uses the standard 4-bit encoding so tap_state can be
// compared directly against the standard; every output is a decode of the
// registered state, so nothing downstream sees a TMS-to-output path.
module tap_controller (
    input  logic TCK,
    input  logic TRST,
    tap_if.slave bus
);

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PAU_DR = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PAU_IR = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    tap_state_t state;
    tap_state_t state_next;

    // State register; TRST pulls the controller into Test-Logic-Reset at once,
    // abandoning any scan in progress without passing through an Update state.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state function: the DR and IR columns share the same shape.
    always_comb begin
        state_next = TLR;
        case (state)
            TLR:    state_next = bus.TMS ? TLR    : RTI;
            RTI:    state_next = bus.TMS ? SEL_DR : RTI;
            SEL_DR: state_next = bus.TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_next = bus.TMS ? EX1_DR : SH_DR;
            SH_DR:  state_next = bus.TMS ? EX1_DR : SH_DR;
            EX1_DR: state_next = bus.TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_next = bus.TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_next = bus.TMS ? UPD_DR : SH_DR;
            UPD_DR: state_next = bus.TMS ? SEL_DR : RTI;
            SEL_IR: state_next = bus.TMS ? TLR    : CAP_IR;
            CAP_IR: state_next = bus.TMS ? EX1_IR : SH_IR;
            SH_IR:  state_next = bus.TMS ? EX1_IR : SH_IR;
            EX1_IR: state_next = bus.TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_next = bus.TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_next = bus.TMS ? UPD_IR : SH_IR;
            UPD_IR: state_next = bus.TMS ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    // Moore decodes of the registered state; each strobe lasts exactly as
    // long as the FSM sits in the matching state.
    always_comb begin
        bus.tap_state  = state;
        bus.tlr_reset  = (state == TLR);
        bus.run_idle   = (state == RTI);
        bus.dr_capture = (state == CAP_DR);
        bus.dr_shift   = (state == SH_DR);
        bus.dr_update  = (state == UPD_DR);
        bus.ir_capture = (state == CAP_IR);
        bus.ir_shift   = (state == SH_IR);
        bus.ir_update  = (state == UPD_IR);
        bus.ir_select  = 1'b0;
        case (state)
            SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR:
                bus.ir_select = 1'b1;
            default:
                bus.ir_select = 1'b0;
        endcase
    end

endmodule
